// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the FIFO controller slice.
//   clogb2(v) : number of bits needed to represent the value v. The RAM uses
//               the same definition, so address widths derived from it match
//               the attached sram_tp_true instance.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int c_skid_depth = 2;

  function automatic int clogb2(input int value);
    int v;
    int res;
    v   = value;
    res = 0;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/skid_buf_2.sv
// -----------------------------------------------------------------------------
// skid_buf_2
// Two-entry registered FIFO that catches the RAM's read data and presents it
// as a valid/ready stream. The upstream issue logic guarantees that a word
// only arrives when there is room (counting a same-cycle pop), so there is
// no input-side ready.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   a returned RAM word is present on in_data this cycle
//   in_data    returned RAM word
//   out_valid  head entry is valid
//   out_ready  downstream accepts the head this cycle
//   out_data   head entry (registered)
//   count      entries held (0..2)
// -----------------------------------------------------------------------------
module skid_buf_2 #(
  parameter int g_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [g_W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [g_W-1:0] out_data,
  output logic [1:0]     count
);

  logic [g_W-1:0] r_head;
  logic [g_W-1:0] r_tail;
  logic [1:0]     r_count;
  logic           w_pop;

  assign w_pop     = (r_count != 2'd0) & out_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_head;
  assign count     = r_count;

  // NOTE: the two data registers are reset along with the count so m_data is
  // a known value straight out of reset; with only two entries this is cheap,
  // unlike the RAM itself, which is never cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({in_valid, w_pop})
        2'b10: begin
          // A full buffer without a pop cannot receive a word; ignore it.
          if (r_count == 2'd0) begin
            r_head  <= in_data;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_tail  <= in_data;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Push and pop together: count unchanged, order preserved.
          if (r_count == 2'd1) begin
            r_head <= in_data;
          end else begin
            r_head <= r_tail;
            r_tail <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_tp_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_tp_ctrl
// Single-clock first-word-fall-through FIFO controller for an external
// true-dual-port RAM (port A writes, port B reads). The RAM's registered read
// is turned back into a valid/ready stream through skid_buf_2.
// Ports:
//   clk, rst              clock (also clocks the RAM), async active-high reset
//   s_valid/s_ready/s_data   input stream
//   m_valid/m_ready/m_data   output stream, m_data is the FIFO head
//   level                 words held: RAM + in-flight read + skid (registered)
//   ram_addra/ena/wea/dina   RAM port A (write side)
//   ram_addrb/enb/web/dinb   RAM port B (read side, web/dinb tied off)
//   ram_doutb             RAM port B data, valid the cycle after ram_enb
// -----------------------------------------------------------------------------
module fifo_tp_ctrl
  import fifo_pkg::*;
#(
  parameter int g_D  = 512,
  parameter int g_W  = 16,
  parameter int g_AW = clogb2(g_D - 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [g_W-1:0]         s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [g_W-1:0]         m_data,
  output logic [clogb2(g_D+2):0] level,
  output logic [g_AW-1:0]        ram_addra,
  output logic                   ram_ena,
  output logic                   ram_wea,
  output logic [g_W-1:0]         ram_dina,
  output logic [g_AW-1:0]        ram_addrb,
  output logic                   ram_enb,
  output logic                   ram_web,
  output logic [g_W-1:0]         ram_dinb,
  input  logic [g_W-1:0]         ram_doutb
);

  localparam int              c_lw    = clogb2(g_D + 2) + 1;
  localparam logic [g_AW-1:0] c_last  = g_AW'(g_D - 1);
  localparam logic [c_lw-1:0] c_depth = c_lw'(g_D);

  logic [g_AW-1:0] r_wr_ptr;
  logic [g_AW-1:0] r_rd_ptr;
  logic [c_lw-1:0] r_ram_cnt;
  logic            r_rd_pend;
  logic [c_lw-1:0] r_level;

  logic            w_push;
  logic            w_pop;
  logic            w_issue;
  logic            w_m_valid;
  logic [1:0]      w_skid_cnt;
  logic [1:0]      w_skid_cnt_nxt;
  logic [c_lw-1:0] w_ram_cnt_nxt;

  // Ready depends only on registered state, so a full FIFO refuses a push
  // even in a cycle where it also pops.
  assign s_ready = (r_ram_cnt < c_depth);
  assign w_push  = s_valid & s_ready & ~rst;
  assign w_pop   = w_m_valid & m_ready;

  // Only read when the returning word is guaranteed a skid slot: entries
  // already held plus the one in flight, minus any leaving this cycle.
  assign w_issue = ~rst & (r_ram_cnt != '0) &
                   (({1'b0, w_skid_cnt} + {2'b00, r_rd_pend}) < (3'd2 + {2'b00, w_pop}));

  assign w_ram_cnt_nxt  = r_ram_cnt + c_lw'(w_push) - c_lw'(w_issue);
  assign w_skid_cnt_nxt = w_skid_cnt + {1'b0, r_rd_pend} - {1'b0, w_pop};

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_ram_cnt <= '0;
      r_rd_pend <= 1'b0;
      r_level   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + g_AW'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + g_AW'(1);
      end
      r_ram_cnt <= w_ram_cnt_nxt;
      r_rd_pend <= w_issue;
      r_level   <= w_ram_cnt_nxt + c_lw'(w_issue) + c_lw'(w_skid_cnt_nxt);
    end
  end

  skid_buf_2 #(
    .g_W(g_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (r_rd_pend),
    .in_data  (ram_doutb),
    .out_valid(w_m_valid),
    .out_ready(m_ready),
    .out_data (m_data),
    .count    (w_skid_cnt)
  );

  assign m_valid   = w_m_valid;
  assign level     = r_level;

  assign ram_addra = r_wr_ptr;
  assign ram_ena   = w_push;
  assign ram_wea   = w_push;
  assign ram_dina  = s_data;

  assign ram_addrb = r_rd_ptr;
  assign ram_enb   = w_issue;
  assign ram_web   = 1'b0;
  assign ram_dinb  = '0;

endmodule

// File: tb/tb_fifo_tp_ctrl.sv
module tb_fifo_tp_ctrl;
  import fifo_pkg::*;

  localparam int D   = 8;
  localparam int W   = 16;
  localparam int AW  = clogb2(D - 1);
  localparam int LW  = clogb2(D + 2) + 1;
  localparam int D6  = 6;
  localparam int AW6 = clogb2(D6 - 1);
  localparam int LW6 = clogb2(D6 + 2) + 1;

  logic clk;
  logic rst;

  // g_D = 8 instance
  logic          s_valid, s_ready, m_valid, m_ready;
  logic [W-1:0]  s_data, m_data;
  logic [LW-1:0] level;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [W-1:0]  ram_dina, ram_dinb, ram_doutb;

  // g_D = 6 instance
  logic           s_valid6, s_ready6, m_valid6, m_ready6;
  logic [W-1:0]   s_data6, m_data6;
  logic [LW6-1:0] level6;
  logic [AW6-1:0] ram_addra6, ram_addrb6;
  logic           ram_ena6, ram_wea6, ram_enb6, ram_web6;
  logic [W-1:0]   ram_dina6, ram_dinb6, ram_doutb6;

  int n_pass;
  int n_total;

  // Reference model: words currently held, in order, plus expected RAM addresses.
  logic [W-1:0] q[$];
  int exp_wa;
  int exp_ra;

  fifo_tp_ctrl #(.g_D(D), .g_W(W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ram_addra(ram_addra), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_web(ram_web), .ram_dinb(ram_dinb),
    .ram_doutb(ram_doutb)
  );

  fifo_tp_ctrl #(.g_D(D6), .g_W(W)) dut6 (
    .clk(clk), .rst(rst),
    .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data6),
    .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6),
    .level(level6),
    .ram_addra(ram_addra6), .ram_ena(ram_ena6), .ram_wea(ram_wea6), .ram_dina(ram_dina6),
    .ram_addrb(ram_addrb6), .ram_enb(ram_enb6), .ram_web(ram_web6), .ram_dinb(ram_dinb6),
    .ram_doutb(ram_doutb6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAMs with a one-cycle registered read.
  logic [W-1:0] mem8 [0:D-1];
  logic [W-1:0] mem6 [0:D6-1];

  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem8[ram_addra] <= ram_dina;
    if (ram_enb) ram_doutb <= mem8[ram_addrb];
  end

  always @(posedge clk) begin
    if (ram_ena6 && ram_wea6 && int'(ram_addra6) < D6) mem6[ram_addra6] <= ram_dina6;
    if (ram_enb6 && int'(ram_addrb6) < D6) ram_doutb6 <= mem6[ram_addrb6];
  end

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Samples the g_D=8 instance at the falling edge and checks it against the model.
  task automatic sample();
    @(negedge clk);
    if (rst) begin
      q.delete();
      exp_wa = 0;
      exp_ra = 0;
    end else begin
      n_total++;
      if (level !== LW'(q.size()))
        $display("FAIL sb_level: got %0d expected %0d", level, q.size());
      else n_pass++;

      if (q.size() < D) begin
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL sb_s_ready_room: got %b expected 1 (held %0d)", s_ready, q.size());
        else n_pass++;
      end else if (q.size() == D + 2) begin
        n_total++;
        if (s_ready !== 1'b0) $display("FAIL sb_s_ready_full: got %b expected 0", s_ready);
        else n_pass++;
      end

      if (q.size() == 0) begin
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL sb_m_valid_empty: got %b expected 0", m_valid);
        else n_pass++;
      end

      n_total++;
      if (ram_ena !== (s_valid & s_ready) || ram_wea !== ram_ena || ram_web !== 1'b0)
        $display("FAIL sb_ram_en: ena=%b wea=%b web=%b expected ena=wea=%b web=0",
                 ram_ena, ram_wea, ram_web, s_valid & s_ready);
      else n_pass++;

      if (ram_ena) begin
        n_total++;
        if (ram_addra !== AW'(exp_wa) || ram_dina !== s_data)
          $display("FAIL sb_write: addra=%0d dina=%h expected addra=%0d dina=%h",
                   ram_addra, ram_dina, exp_wa, s_data);
        else n_pass++;
        exp_wa = (exp_wa + 1) % D;
      end

      if (ram_enb) begin
        n_total++;
        if (ram_addrb !== AW'(exp_ra))
          $display("FAIL sb_read_addr: addrb=%0d expected %0d", ram_addrb, exp_ra);
        else n_pass++;
        exp_ra = (exp_ra + 1) % D;
      end

      if (m_valid && m_ready) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL sb_pop_empty: got word %h expected no word", m_data);
        end else begin
          if (m_data !== q[0]) $display("FAIL sb_data: got %h expected %h", m_data, q[0]);
          else n_pass++;
          void'(q.pop_front());
        end
      end

      if (s_valid && s_ready) q.push_back(s_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 16'h5555; m_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_total++;
      if (m_valid !== 1'b0 || level !== '0 || s_ready !== 1'b1 || ram_ena !== 1'b0 || ram_enb !== 1'b0)
        $display("FAIL reset_hold: m_valid=%b level=%0d s_ready=%b ena=%b enb=%b expected 0,0,1,0,0",
                 m_valid, level, s_ready, ram_ena, ram_enb);
      else n_pass++;
      advance();
    end
    rst = 1'b0; s_valid = 1'b0;
    sample();
    n_total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) $display("FAIL reset_after: s_ready=%b m_valid=%b expected 1,0", s_ready, m_valid);
    else n_pass++;
    advance();
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_data = 16'hA5A5; m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (c == 0) begin
        n_total++;
        if (ram_ena !== 1'b1 || ram_addra !== '0) $display("FAIL single_write: ena=%b addra=%0d expected 1,0", ram_ena, ram_addra);
        else n_pass++;
      end
      if (c == 1) begin
        n_total++;
        if (ram_enb !== 1'b1 || ram_addrb !== '0) $display("FAIL single_issue: enb=%b addrb=%0d expected 1,0", ram_enb, ram_addrb);
        else n_pass++;
      end
      if (c == 1 || c == 2) begin
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL single_early: cycle %0d m_valid=%b expected 0", c, m_valid);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 16'hA5A5) $display("FAIL single_out: m_valid=%b m_data=%h expected 1,a5a5", m_valid, m_data);
        else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if (level !== '0) $display("FAIL single_level: got %0d expected 0", level);
        else n_pass++;
      end
      advance();
      s_valid = 1'b0;
    end
  endtask

  task automatic test_fill_drain();
    int idx;
    int accepted;
    idx = 0; accepted = 0; m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      s_valid = (idx < 12);
      s_data  = W'(idx);
      sample();
      if (s_valid && s_ready) begin
        accepted++;
        idx++;
      end
      advance();
    end
    s_valid = 1'b0;
    sample();
    n_total++;
    if (accepted != 10 || level !== LW'(10) || s_ready !== 1'b0)
      $display("FAIL fill_full: accepted=%0d level=%0d s_ready=%b expected 10,10,0", accepted, level, s_ready);
    else n_pass++;
    advance();
    m_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sample();
      n_total++;
      if (m_valid !== 1'b1 || m_data !== W'(k))
        $display("FAIL drain_word: m_valid=%b m_data=%h expected 1,%h", m_valid, m_data, W'(k));
      else n_pass++;
      advance();
    end
    sample();
    n_total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) $display("FAIL drain_end: s_ready=%b m_valid=%b expected 1,0", s_ready, m_valid);
    else n_pass++;
    advance();
  endtask

  task automatic test_streaming();
    m_ready = 1'b1;
    for (int c = 0; c < 106; c++) begin
      s_valid = (c < 100);
      s_data  = W'(c);
      sample();
      if (c < 3) begin
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL stream_fill: cycle %0d m_valid=%b expected 0", c, m_valid);
        else n_pass++;
      end else if (c < 103) begin
        n_total++;
        if (m_valid !== 1'b1 || m_data !== W'(c - 3))
          $display("FAIL stream_word: cycle %0d m_valid=%b m_data=%h expected 1,%h", c, m_valid, m_data, W'(c - 3));
        else n_pass++;
      end
      if (c >= 3 && c < 100) begin
        n_total++;
        if (level !== LW'(3)) $display("FAIL stream_level: cycle %0d got %0d expected 3", c, level);
        else n_pass++;
      end
      advance();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = W'($urandom);
      m_ready = (c < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      sample();
      advance();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      sample();
      advance();
    end
    n_total++;
    if (q.size() != 0) $display("FAIL random_drain: %0d words left expected 0", q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic got;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = W'(16'h0050 + i);
      sample();
      advance();
    end
    s_valid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      sample();
      got = m_valid;
      advance();
    end
    n_total++;
    if (!got) $display("FAIL mid_wait: m_valid=0 expected 1 within 10 cycles");
    else n_pass++;
    m_ready = 1'b1;
    sample();
    advance();
    m_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_total++;
    if (level !== '0 || m_valid !== 1'b0) $display("FAIL mid_reset: level=%0d m_valid=%b expected 0,0", level, m_valid);
    else n_pass++;
    sample();
    advance();
    rst = 1'b0; s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (c < 3) begin
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL mid_stale: cycle %0d m_valid=%b expected 0", c, m_valid);
        else n_pass++;
      end else if (c == 3) begin
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 16'h1234) $display("FAIL mid_first: m_valid=%b m_data=%h expected 1,1234", m_valid, m_data);
        else n_pass++;
      end
      advance();
      s_valid = 1'b0;
    end
  endtask

  task automatic test_wrap6();
    int n_sent, n_recv, wa, ra, n_wr, n_rd;
    n_sent = 0; n_recv = 0; wa = 0; ra = 0; n_wr = 0; n_rd = 0;
    for (int c = 0; c < 200 && n_recv < 20; c++) begin
      s_valid6 = (n_sent < 20);
      s_data6  = W'(16'h0C00 + n_sent);
      m_ready6 = (c % 2 == 0);
      @(negedge clk);
      if (ram_ena6) begin
        n_total++;
        if (ram_addra6 !== AW6'(wa)) $display("FAIL wrap_addra: got %0d expected %0d", ram_addra6, wa);
        else n_pass++;
        wa = (wa + 1) % D6;
        n_wr++;
      end
      if (ram_enb6) begin
        n_total++;
        if (ram_addrb6 !== AW6'(ra)) $display("FAIL wrap_addrb: got %0d expected %0d", ram_addrb6, ra);
        else n_pass++;
        ra = (ra + 1) % D6;
        n_rd++;
      end
      if (m_valid6 && m_ready6) begin
        n_total++;
        if (m_data6 !== W'(16'h0C00 + n_recv)) $display("FAIL wrap_data: got %h expected %h", m_data6, W'(16'h0C00 + n_recv));
        else n_pass++;
        n_recv++;
      end
      if (s_valid6 && s_ready6) n_sent++;
      advance();
    end
    s_valid6 = 1'b0; m_ready6 = 1'b0;
    n_total++;
    if (n_recv != 20 || n_wr != 20 || n_rd != 20)
      $display("FAIL wrap_counts: recv=%0d writes=%0d reads=%0d expected 20,20,20", n_recv, n_wr, n_rd);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    exp_wa = 0; exp_ra = 0;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    s_valid6 = 1'b0; s_data6 = '0; m_ready6 = 1'b0;
    advance();
    advance();
    test_reset();
    test_single();
    test_fill_drain();
    test_streaming();
    test_random();
    test_reset_midstream();
    test_wrap6();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_tp_ctrl.md
Name: fifo_tp_ctrl

Overview:
- Single-clock first-word-fall-through FIFO controller that drives an external sram_tp_true instance.
- Port A of the RAM is the write side; port B is the read side.
- Converts the RAM's one-cycle registered read into a valid/ready output stream through a 2-entry output skid buffer.
- Sits directly upstream of the RAM: it produces the addresses and enables, and consumes doutb.

Parameters:
- g_D, 512, RAM depth in words. Any value ≥ 2; power of two not required.
- g_W, 16, data width.
- g_AW, clogb2(g_D-1), RAM address width. Derived; never overridden. Matches the sram_tp_true address width.

Ports:
- clk  in  1  sole clock; also drives clka/clkb of the RAM.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input can accept.
- s_data  in  g_W  input word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts.
- m_data  out  g_W  output word (head of FIFO).
- level  out  clogb2(g_D+2)+1  total words held (RAM + in-flight read + skid).
- ram_addra  out  g_AW  write address.
- ram_ena  out  1  port A enable.
- ram_wea  out  1  port A write enable.
- ram_dina  out  g_W  write data.
- ram_addrb  out  g_AW  read address.
- ram_enb  out  1  port B enable.
- ram_web  out  1  tied 0.
- ram_dinb  out  g_W  tied 0.
- ram_doutb  in  g_W  RAM port B read data; valid the cycle after ram_enb is sampled.

Behaviour:
- Definitions:
  - push = s_valid & s_ready
  - pop = m_valid & m_ready
  - issue = ram_enb
- State: wr_ptr, rd_ptr (0..g_D-1), ram_cnt (0..g_D), rd_pend (1 bit), skid_cnt (0..2), 2 skid data regs.
- Reset (async assert; deassert synchronous to clk):
  - All state cleared to 0.
  - m_valid=0, level=0.
  - ram_ena=ram_wea=ram_enb=0 while rst=1.
  - s_ready=1 the first cycle after reset.
  - RAM contents are not cleared.
- Write side:
  - s_ready = (ram_cnt < g_D); combinational from registered state, independent of s_valid.
  - ram_ena = ram_wea = push; ram_addra = wr_ptr; ram_dina = s_data.
  - wr_ptr advances on push, wrapping g_D-1 → 0.
- Read issue:
  - issue = (ram_cnt > 0) & (skid_cnt + rd_pend - pop < 2).
  - ram_addrb = rd_ptr; rd_ptr advances on issue with the same wrap rule.
  - rd_pend <= issue.
- Counter update:
  - ram_cnt <= ram_cnt + push - issue.
  - A word pushed in cycle N is not issued before N+1.
  - No read address ever equals a same-cycle write address, so the write-first collision case never occurs.
- Return path:
  - When rd_pend=1, ram_doutb is written into the skid at the end of that cycle.
  - The skid is a 2-entry FIFO. Push from the return path and pop from m_ready may occur in the same cycle; the count is unchanged and order is preserved.
- Output: m_valid = (skid_cnt > 0); m_data = skid head, registered.
  - Latency: push at cycle N into an empty FIFO → m_valid=1 at cycle N+3.
- Throughput: one word per cycle sustained with s_valid=m_ready=1 after the initial 3-cycle fill.
- Capacity: g_D+2 words. With m_ready=0, skid fills first, then RAM.
- level = ram_cnt + rd_pend + skid_cnt, registered.
- Reset mid-operation: the in-flight read is discarded, the skid is emptied, and pointers return to 0. Words pushed after reset are the only ones ever delivered.
- Simultaneous push and pop when full (level = g_D+2): pop proceeds. The push is refused that cycle because s_ready is from registered ram_cnt; it is accepted the next cycle.

Decomposition:
- Package fifo_pkg: the clogb2 function (same definition as sram_tp_true) and any shared width constants.
- One sub-module, skid_buf_2: 2-entry registered valid/ready buffer with in_valid, in_data, out_valid, out_ready, out_data, count[1:0].
- Pointers, counters and issue logic live in the top.

Test Plan (g_D=8, g_W=16 unless noted):
- Reset: assert rst mid-idle → m_valid=0, level=0, s_ready=1, ram_ena=ram_enb=0 throughout reset.
- Single word: push 0xA5A5 at cycle 0, m_ready=1 → ram_addra=0 at cycle 0, ram_enb=1 with addrb=0 at cycle 1, m_valid=1 with m_data=0xA5A5 at cycle 3, level returns to 0 at cycle 4.
- Fill/drain: m_ready=0, offer 0x0000..0x000B → exactly 10 accepted, s_ready=0 at level=10. Then m_ready=1 → outputs 0x0000..0x0009 in order, one per cycle, and s_ready reasserts.
- Streaming: s_valid=m_ready=1, 100 incrementing words → first output at cycle 3, then no bubble, all 100 in order, level constant at 3.
- Non-power-of-two wrap: g_D=6, stream 20 words with m_ready toggling 1,0 → ram_addra/ram_addrb sequence 0..5,0..5,…; no value ≥6 and no loss or duplication.
- Reset mid-stream: after 5 pushes and 1 pop, pulse rst for 1 cycle → level=0 and m_valid=0 immediately. Next push 0x1234 is the first word out, at cycle +3.
